stream_demux_1to4: RTL

//   Routes one valid/ready input stream to one of four output channels, selected by a 2-bit select.
//   It is the inverse of the 4:1 select path and uses the same select mapping.

---
 rtl/stream_demux_1to4.sv | 116 +++++++++++
 1 files changed

// File: rtl/stream_demux_1to4.sv
// -----------------------------------------------------------------------------
// stream_demux_1to4
//   Routes one valid/ready input stream to one of four output channels. The
//   channel is picked by in_sel on the first beat of a packet and then held
//   until the in_last beat, so a packet is never split across channels. Each
//   channel has a one-entry output register. A stalled channel only blocks
//   input traffic that is headed for that channel.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input beat present
//   in_ready   input beat accepted when in_valid & in_ready
//   in_data    input beat payload (DATA_W bits)
//   in_last    final beat of a packet
//   in_sel     destination channel, sampled only on a packet's first beat
//   out_valid  per-channel beat present (bit k = channel k)
//   out_ready  per-channel consumer ready
//   out_data   channel k occupies [k*DATA_W +: DATA_W]
//   out_last   per-channel last flag
//   busy       1 while a packet is partway through (route locked)
// -----------------------------------------------------------------------------
module stream_demux_1to4 #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  input  logic [1:0]            in_sel,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [3:0]            out_last,
  output logic                  busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] lock_sel;
  logic [1:0] route;
  logic       accept;

  // In IDLE the route follows in_sel live. If in_sel changes while a beat is
  // waiting, the route is re-evaluated. Once a packet has started, the
  // latched channel is used.
  always_comb begin
    // NOTE: give every always_comb output a default first, so no path leaves it unassigned and a latch gets inferred.
    route = in_sel;
    if (state == LOCKED) route = lock_sel;
  end

  // Only the selected channel's register decides readiness. A full register
  // that drains this cycle can take a new beat in the same cycle.
  assign in_ready = !out_valid[route] || out_ready[route];
  assign accept   = in_valid && in_ready;

  // Packet-lock FSM. busy is kept as its own flop that tracks the LOCKED state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      state    <= IDLE;
      lock_sel <= 2'd0;
      busy     <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          // A 1-beat packet (in_last on the first beat) leaves the FSM in IDLE.
          if (!in_last) begin
            state    <= LOCKED;
            lock_sel <= in_sel;
            busy     <= 1'b1;
          end
        end
        LOCKED: begin
          if (in_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel one-entry output registers. A load takes priority over a
  // drain, which gives full throughput. A drain alone clears only the valid
  // bit, and the payload stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_last  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (route == 2'(k))) begin
          out_valid[k]                  <= 1'b1;
          out_data[k*DATA_W +: DATA_W]  <= in_data;
          out_last[k]                   <= in_last;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule
